ppu_id_ex_pipe: RTL and testbench

//   Front half of the PPU pipeline datapath:
//   - nPC+4 incrementer (Adder_4 function).
//   - ID-stage register for the 17-bit control bundle, with a bubble mux in front of it.
//   - EX-stage register fed from the ID register.

---
 rtl/ppu_id_ex_pipe.sv | 90 +++++++++
 tb/tb_ppu_id_ex_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ppu_id_ex_pipe.sv
// PPU front pipeline: nPC incrementer, bubble mux, ID and EX control/PC registers.
// Optional stall input is compiled in when PPU_PIPE_STALL_EN is defined.
module ppu_id_ex_pipe #(
  parameter int CTRL_W = 17,
  parameter int ADDR_W = 32,
  parameter int INC    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] npc_in,
  output logic [ADDR_W-1:0] npc_plus4,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  input  logic [ADDR_W-1:0] id_pc_in,
  input  logic              bubble,
`ifdef PPU_PIPE_STALL_EN
  input  logic              stall,
`endif
  output logic [CTRL_W-1:0] id_ctrl_q,
  output logic [CTRL_W-1:0] ex_ctrl_q,
  output logic [ADDR_W-1:0] ex_pc_q,
  output logic [2:0]        ex_alu_op,
  output logic              ex_load,
  output logic [2:0]        ex_so_sel,
  output logic              ex_rf_en,
  output logic              ex_branch,
  output logic              ex_ta,
  output logic              ex_mem_en,
  output logic              ex_mem_se,
  output logic              ex_mem_rw,
  output logic [1:0]        ex_mem_size,
  output logic              ex_hi_en,
  output logic              ex_lo_en
);

  logic [CTRL_W-1:0] mux_out;
  logic              advance;
  logic [CTRL_W-1:0] id_ctrl_d, ex_ctrl_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d, ex_pc_d;

  assign npc_plus4 = npc_in + ADDR_W'(INC);

`ifdef PPU_PIPE_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  // Bubble zeroes only the control bundle; the PC still travels with the slot.
  always_comb begin
    mux_out   = bubble ? '0 : id_ctrl_in;
    id_ctrl_d = id_ctrl_q;
    id_pc_d   = id_pc_q;
    ex_ctrl_d = ex_ctrl_q;
    ex_pc_d   = ex_pc_q;
    if (advance) begin
      id_ctrl_d = mux_out;
      id_pc_d   = id_pc_in;
      ex_ctrl_d = id_ctrl_q;
      ex_pc_d   = id_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ctrl_q <= '0;
      id_pc_q   <= '0;
      ex_ctrl_q <= '0;
      ex_pc_q   <= '0;
    end else begin
      id_ctrl_q <= id_ctrl_d;
      id_pc_q   <= id_pc_d;
      ex_ctrl_q <= ex_ctrl_d;
      ex_pc_q   <= ex_pc_d;
    end
  end

  assign ex_alu_op   = ex_ctrl_q[16:14];
  assign ex_load     = ex_ctrl_q[13];
  assign ex_so_sel   = ex_ctrl_q[12:10];
  assign ex_rf_en    = ex_ctrl_q[9];
  assign ex_branch   = ex_ctrl_q[8];
  assign ex_ta       = ex_ctrl_q[7];
  assign ex_mem_en   = ex_ctrl_q[6];
  assign ex_mem_se   = ex_ctrl_q[5];
  assign ex_mem_rw   = ex_ctrl_q[4];
  assign ex_mem_size = ex_ctrl_q[3:2];
  assign ex_hi_en    = ex_ctrl_q[1];
  assign ex_lo_en    = ex_ctrl_q[0];

endmodule

// File: tb/tb_ppu_id_ex_pipe.sv
// Self-checking bench for ppu_id_ex_pipe; reference model is a history queue of
// bundles that entered the pipe (last = ID stage, the one before = EX stage).
module tb_ppu_id_ex_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in, npc_plus4;
  logic [16:0] id_ctrl_in;
  logic [31:0] id_pc_in;
  logic        bubble;
`ifdef PPU_PIPE_STALL_EN
  logic        stall;
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif
  logic [16:0] id_ctrl_q, ex_ctrl_q;
  logic [31:0] ex_pc_q;
  logic [2:0]  ex_alu_op, ex_so_sel;
  logic        ex_load, ex_rf_en, ex_branch, ex_ta, ex_mem_en, ex_mem_se, ex_mem_rw;
  logic [1:0]  ex_mem_size;
  logic        ex_hi_en, ex_lo_en;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [16:0] c;
    logic [31:0] p;
  } ent_t;
  ent_t mq[$];

  ppu_id_ex_pipe dut (
    .clk(clk), .reset(reset), .npc_in(npc_in), .npc_plus4(npc_plus4),
    .id_ctrl_in(id_ctrl_in), .id_pc_in(id_pc_in), .bubble(bubble),
`ifdef PPU_PIPE_STALL_EN
    .stall(stall),
`endif
    .id_ctrl_q(id_ctrl_q), .ex_ctrl_q(ex_ctrl_q), .ex_pc_q(ex_pc_q),
    .ex_alu_op(ex_alu_op), .ex_load(ex_load), .ex_so_sel(ex_so_sel),
    .ex_rf_en(ex_rf_en), .ex_branch(ex_branch), .ex_ta(ex_ta),
    .ex_mem_en(ex_mem_en), .ex_mem_se(ex_mem_se), .ex_mem_rw(ex_mem_rw),
    .ex_mem_size(ex_mem_size), .ex_hi_en(ex_hi_en), .ex_lo_en(ex_lo_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t id_e, ex_e;
    logic [31:0] exp_npc;
    id_e = mq[mq.size()-1];
    ex_e = mq[0];
    exp_npc = npc_in + 32'd4;
    chk("npc_plus4", 64'(npc_plus4), 64'(exp_npc));
    chk("id_ctrl_q", 64'(id_ctrl_q), 64'(id_e.c));
    chk("ex_ctrl_q", 64'(ex_ctrl_q), 64'(ex_e.c));
    chk("ex_pc_q",   64'(ex_pc_q),   64'(ex_e.p));
    chk("ex_fields", 64'({ex_alu_op, ex_load, ex_so_sel, ex_rf_en, ex_branch, ex_ta,
                          ex_mem_en, ex_mem_se, ex_mem_rw, ex_mem_size, ex_hi_en, ex_lo_en}),
                     64'({ex_e.c[16:14], ex_e.c[13], ex_e.c[12:10], ex_e.c[9], ex_e.c[8],
                          ex_e.c[7], ex_e.c[6], ex_e.c[5], ex_e.c[4], ex_e.c[3:2],
                          ex_e.c[1], ex_e.c[0]}));
  endtask

  // Apply one clock edge with the given inputs, advance the model, check outputs.
  task automatic step(input logic rst, input logic [16:0] c, input logic [31:0] pc,
                      input logic bub, input logic stl);
    ent_t e;
    reset      = rst;
    id_ctrl_in = c;
    id_pc_in   = pc;
    bubble     = bub;
    npc_in     = $urandom;
`ifdef PPU_PIPE_STALL_EN
    stall      = stl;
`endif
    @(posedge clk);
    if (rst) begin
      e.c = '0; e.p = '0;
      mq.push_back(e);
      mq.push_back(e);
    end else if (!(STALL_ON && stl)) begin
      e.c = bub ? 17'h0 : c;
      e.p = pc;
      mq.push_back(e);
    end
    while (mq.size() > 2) void'(mq.pop_front());
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; id_ctrl_in = '0; id_pc_in = '0; bubble = 1'b0; npc_in = '0;
`ifdef PPU_PIPE_STALL_EN
    stall = 1'b0;
`endif

    // Incrementer corners
    npc_in = 32'h0000_0000; #1;
    chk("npc_zero", 64'(npc_plus4), 64'h4);
    npc_in = 32'hFFFF_FFFC; #1;
    chk("npc_wrap", 64'(npc_plus4), 64'h0);

    // Reset with all-ones input
    step(1'b1, 17'h1FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 17'h1FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rst_id", 64'(id_ctrl_q), 64'h0);
    chk("rst_lo", 64'(ex_lo_en), 64'h0);

    // Two-cycle latency and decode
    step(1'b0, 17'h1C001, 32'h0000_1000, 1'b0, 1'b0);
    chk("lat_id", 64'(id_ctrl_q), 64'h1C001);
    step(1'b0, 17'h00000, 32'h0000_1004, 1'b0, 1'b0);
    chk("lat_ex",  64'(ex_ctrl_q), 64'h1C001);
    chk("alu_op",  64'(ex_alu_op), 64'h7);
    chk("lo_en",   64'(ex_lo_en),  64'h1);
    chk("lat_pc",  64'(ex_pc_q),   64'h1000);

    // Bubble zeroes control but keeps PC
    step(1'b0, 17'h00240, 32'h0000_2000, 1'b1, 1'b0);
    chk("bub_id", 64'(id_ctrl_q), 64'h0);
    step(1'b0, 17'h00000, 32'h0000_2004, 1'b0, 1'b0);
    chk("bub_ex", 64'(ex_ctrl_q), 64'h0);
    chk("bub_pc", 64'(ex_pc_q),   64'h2000);

    // Mid-stream reset flushes both stages
    step(1'b0, 17'h00200, 32'h0000_3000, 1'b0, 1'b0);
    step(1'b0, 17'h00040, 32'h0000_3004, 1'b0, 1'b0);
    step(1'b1, 17'h00080, 32'h0000_3008, 1'b1, 1'b1);
    chk("flush_id", 64'(id_ctrl_q), 64'h0);
    chk("flush_ex", 64'(ex_ctrl_q), 64'h0);

`ifdef PPU_PIPE_STALL_EN
    step(1'b0, 17'h00200, 32'h0000_4000, 1'b0, 1'b0);
    step(1'b0, 17'h00000, 32'h0000_4004, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 17'h0000C, 32'h0000_4008, i[0], 1'b1);
      chk("stall_hold", 64'(ex_ctrl_q), 64'h00200);
    end
    step(1'b0, 17'h0000C, 32'h0000_4008, 1'b0, 1'b0);
    step(1'b0, 17'h00000, 32'h0000_400C, 1'b0, 1'b0);
    chk("stall_rel", 64'(ex_ctrl_q), 64'h0000C);
`endif

    // Randomized traffic against the history model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 17'($urandom), $urandom,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
